// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, widths and FSM state type
package des_pkg;

   localparam int KEY_W        = 64;
   localparam int SUBKEY_W     = 48;
   localparam int NROUNDS      = 16;
   localparam int ROUND_KEYS_W = 768;
   localparam int HALF_W       = 28;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32};

   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ks_state_e;

   // FIPS numbering: index 1 is the MSB of both the key and the result.
   function automatic logic [1:56] pc1_perm(input logic [1:64] k);
      logic [1:56] r;
      for (int n = 1; n <= 56; n++) r[n] = k[PC1[n-1]];
      return r;
   endfunction

endpackage

// File: rtl/des_ks_round.sv
// rtl/des_ks_round.sv - one combinational DES key schedule round: rotate C/D, apply PC-2
module des_ks_round
   import des_pkg::*;
(
   input  logic [1:28] c_i,
   input  logic [1:28] d_i,
   input  logic [4:0]  rnd_i,
   output logic [1:28] c_o,
   output logic [1:28] d_o,
   output logic [1:48] k_o
);

   logic        shift_two;
   logic [1:56] cd;
   logic        unused_cd;

   always_comb begin
      shift_two = 1'b0;
      for (int n = 0; n < NROUNDS; n++) begin
         if (rnd_i == 5'(n + 1)) shift_two = (SHIFTS[n] == 2);
      end
   end

   assign c_o = shift_two ? {c_i[3:28], c_i[1:2]} : {c_i[2:28], c_i[1]};
   assign d_o = shift_two ? {d_i[3:28], d_i[1:2]} : {d_i[2:28], d_i[1]};
   assign cd  = {c_o, d_o};

   always_comb begin
      k_o = '0;
      for (int n = 1; n <= SUBKEY_W; n++) k_o[n] = cd[PC2[n-1]];
   end

   // PC-2 discards these eight positions of C||D.
   assign unused_cd = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES key schedule, ROUNDS_PER_CYCLE subkeys per clock; KEY_PARITY_CHECK_EN adds key parity flag
module des_key_schedule
   import des_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:64]  key,
   input  logic         decrypt,
   output logic         busy,
   output logic         done,
   output logic [1:768] round_keys,
   output logic         parity_err
);

   localparam int R = ROUNDS_PER_CYCLE;

   if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16) begin : g_bad_rounds
      $error("des_key_schedule: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   ks_state_e    state_q, state_d;
   logic [4:0]   ctr_q, ctr_d;
   logic [1:28]  creg_q, creg_d;
   logic [1:28]  dreg_q, dreg_d;
   logic         dec_q, dec_d;
   logic [1:768] rk_q, rk_d;
   logic [1:56]  key_cd;
   logic         accept;

   logic [1:28]  c_w   [0:R];
   logic [1:28]  d_w   [0:R];
   logic [1:48]  k_w   [0:R-1];
   logic [4:0]   rnd_w [0:R-1];

   assign key_cd = pc1_perm(key);
   assign c_w[0] = creg_q;
   assign d_w[0] = dreg_q;

   for (genvar j = 0; j < R; j++) begin : g_round
      assign rnd_w[j] = ctr_q + 5'(j + 1);
      des_ks_round u_round (
         .c_i   (c_w[j]),
         .d_i   (d_w[j]),
         .rnd_i (rnd_w[j]),
         .c_o   (c_w[j+1]),
         .d_o   (d_w[j+1]),
         .k_o   (k_w[j])
      );
   end

`ifdef KEY_PARITY_CHECK_EN
   logic perr_q, perr_d;
   logic key_par_bad;

   always_comb begin
      key_par_bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (~^key[8*b+1 +: 8]) key_par_bad = 1'b1;
      end
   end

   always_comb begin
      perr_d = perr_q;
      if (accept) perr_d = key_par_bad;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perr_q <= 1'b0;
      else        perr_q <= perr_d;
   end

   assign parity_err = perr_q;
`else
   logic unused_par;
   assign unused_par = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      creg_d  = creg_q;
      dreg_d  = dreg_q;
      dec_d   = dec_q;
      rk_d    = rk_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: accept = start;
         ST_RUN: begin
            creg_d = c_w[R];
            dreg_d = d_w[R];
            // Each slot is picked up by whichever chained round maps onto it this cycle.
            for (int s = 1; s <= NROUNDS; s++) begin
               for (int j = 0; j < R; j++) begin
                  if ((dec_q ? (17 - (int'(ctr_q) + j + 1)) : (int'(ctr_q) + j + 1)) == s)
                     rk_d[SUBKEY_W*(s-1)+1 +: SUBKEY_W] = k_w[j];
               end
            end
            ctr_d = ctr_q + 5'(R);
            if (ctr_d == 5'(NROUNDS)) state_d = ST_DONE;
         end
         ST_DONE: begin
            accept  = start;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         creg_d  = key_cd[1:28];
         dreg_d  = key_cd[29:56];
         dec_d   = decrypt;
         ctr_d   = '0;
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ctr_q   <= '0;
         creg_q  <= '0;
         dreg_q  <= '0;
         dec_q   <= 1'b0;
         rk_q    <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         creg_q  <= creg_d;
         dreg_q  <= dreg_d;
         dec_q   <= dec_d;
         rk_q    <= rk_d;
      end
   end

   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign round_keys = rk_q;

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Iterative DES key schedule generator. It sits directly upstream of des_encryption_unroll4 and drives that block's round_keys input.
- Takes a 64-bit DES key (including parity bits) and produces all sixteen 48-bit subkeys, packed as one 768-bit vector.
- Subkey order is selectable: encryption order or reversed (decryption) order.
- Computes ROUNDS_PER_CYCLE subkeys per clock, then signals done. The packed result stays stable until the next start.

Parameters:
- ROUNDS_PER_CYCLE, 1, subkeys computed per clock. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; key and decrypt are sampled on the same edge.
- key  input  [1:64]  DES key, FIPS 46 bit numbering (bit 1 = MSB).
- decrypt  input  1  0 = encryption subkey order, 1 = reversed order.
- busy  output  1  high while a schedule is being computed.
- done  output  1  one-cycle pulse when round_keys is complete.
- round_keys  output  [1:768]  packed subkeys. Bits [1:48] are the subkey for the first round applied, [721:768] for the last.
- parity_err  output  1  key parity flag (see Optional Feature).

Behaviour:
- Reset values: busy=0, done=0, round_keys=0, parity_err=0, FSM=IDLE, round counter=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start, latch PC-1(key) into C[1:28]/D[1:28], latch decrypt, clear counter, go to RUN. busy=1 from the next cycle.
  - RUN: each cycle processes ROUNDS_PER_CYCLE rounds i = ctr+1 .. ctr+R.
    - Left-rotate C and D by SHIFTS[i]: 1 for i in {1,2,9,16}, else 2.
    - Compute K_i = PC-2(C||D).
    - Store K_i into slot s: s=i when decrypt=0, s=17-i when decrypt=1. Slot s occupies bits [48(s-1)+1 : 48s].
    - ctr += R. Once ctr reaches 16, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency: done asserts 16/ROUNDS_PER_CYCLE + 1 cycles after the start edge.
- round_keys is written only in RUN. It holds its value in IDLE and DONE until the next start accepted.
- start while busy=1: ignored. No restart, no error.
- start in the DONE cycle: accepted. done still pulses this cycle, and RUN begins on the next cycle.
- Reset mid-RUN: aborts immediately. All outputs return to reset values and the partial schedule is discarded.
- Parity bits 8, 16, …, 64 never influence round_keys (PC-1 drops them).
- Downstream contract: the consumer may pulse its own start on the same edge that done is high.

Optional Feature:
Macro KEY_PARITY_CHECK_EN.
- Defined:
  - On the accepted start, check odd parity of each key byte.
  - If any byte fails, parity_err=1 from the next cycle until the next accepted start or reset.
  - The schedule is still generated normally.
- Undefined: parity_err is tied to 0 and no parity logic is synthesised.

Decomposition:
- Shared package des_pkg holds:
  - PC1 (56 entries), PC2 (48 entries), SHIFTS (16 entries) constant tables.
  - Width constants: KEY_W=64, SUBKEY_W=48, NROUNDS=16, ROUND_KEYS_W=768.
  - The FSM state typedef.
- One sub-module: des_ks_round. It is a combinational single round: (C, D, round index) → (C', D', K_i).
  - Instantiated ROUNDS_PER_CYCLE times in a chain within RUN.

Test Plan:
1. Key 0x133457799BBCDFF1, decrypt=0, R=1: done 17 cycles after start; round_keys[1:48]=0x1B02EFFC7072, [721:768]=0xCB3D8B0E17F5.
2. Same key, decrypt=1: [1:48]=0xCB3D8B0E17F5, [721:768]=0x1B02EFFC7072. Feed the schedule to des_encryption_unroll4 with ciphertext 0x85E813540F0AB405 → result 0x0123456789ABCDEF.
3. R ∈ {2,4,16}: the test 1 key gives a bit-identical round_keys, and done occurs at 9/5/2 cycles respectively.
4. start re-pulsed mid-RUN with a different key → ignored; output matches the first key. Then rst_n low for 1 cycle mid-RUN → busy, done, round_keys all 0; a fresh start completes correctly.
5. KEY_PARITY_CHECK_EN defined, key 0x0101010101010101 → parity_err=0; key 0x0001010101010101 → parity_err=1, and round_keys still matches the reference model. Macro undefined → parity_err stays 0.
6. Random-key regression of 1000 keys vs the Python model (../python/testfiles); back-to-back start in the DONE cycle is included; all must match.
